register_slice_rr_arbiter: RTL and testbench
============================================

// Module: register_slice_rr_arbiter
// PURPOSE
//  Shares one register-slice output stage between NUM_IN valid/ready requesters using round-robin arbitration.
//  Each cycle one eligible requester is granted. Its beat is captured into a single output register with the
//  same semantics as a register slice: 1-cycle latency, full throughput, backpressure-safe.
//  Sits in front of shared downstream datapaths (e.g. one linear/MAC core fed by several streams).
// PARAMETERS
//  NUM_IN     4   number of requesters (>=1)
//  DATA_WIDTH 32  bits per beat
//  ID_WIDTH   $clog2(NUM_IN) (min 1)  width of the grant-index sideband
// PORTS
//  clk             in   1                     clock, all logic on rising edge
//  rst_n           in   1                     asynchronous active-low reset
//  data_in_data    in   NUM_IN*DATA_WIDTH     requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  data_in_valid   in   NUM_IN                per-requester valid
//  data_in_last    in   NUM_IN                per-requester end-of-packet (used only with lock feature)
//  data_in_ready   out  NUM_IN                per-requester ready, at most one bit high
//  data_out_data   out  DATA_WIDTH            registered winning beat
//  data_out_id     out  ID_WIDTH              index of the requester that produced data_out_data
//  data_out_valid  out  1                     output register holds a beat
//  data_out_ready  in   1                     downstream accepts
// BEHAVIOUR
//  - Reset (async assert, sync deassert externally): data_out_valid=0, data_out_data=0, data_out_id=0, prio_ptr=0, state=IDLE.
//  - load = data_out_ready | ~data_out_valid. Output register updates only when load=1.
//  - Grant (combinational): the first i with data_in_valid[i]=1, scanning prio_ptr, prio_ptr+1, ... mod NUM_IN.
//  - data_in_ready[g] = load for the granted g; all other ready bits = 0. Ready may depend on valid; valid must not depend on ready.
//  - Transfer on requester g = data_in_valid[g] & data_in_ready[g]. Next cycle: data_out_valid=1, data_out_data=beat, data_out_id=g.
//  - load=1 with no valid requester: data_out_valid<=0. data_out_data and data_out_id hold their values.
//  - load=0 (full and stalled): outputs hold, all data_in_ready=0.
//  - Simultaneous drain+fill: output consumed and new beat loaded in the same cycle, so 1 beat/cycle is sustained.
//  - Pointer: after a transfer from g, prio_ptr <= (g==NUM_IN-1) ? 0 : g+1 (wrap). No transfer -> hold.
//  - Latency: input transfer to data_out_valid = 1 cycle. Fairness: a requester held valid waits at most NUM_IN-1 grants.
//  - NUM_IN=1 degenerates to a plain register slice with data_out_id=0.
//  - Reset mid-operation: the beat in the output register is discarded and arbitration restarts from requester 0.
// CONFIGURATION
//  REGISTER_SLICE_ARB_LOCK_EN defined: packet lock, two-state FSM.
//   IDLE: grant per round-robin. A transfer with data_in_last[g]=0 -> LOCKED(lock_id=g), prio_ptr holds.
//   A transfer with last=1 -> stay IDLE and advance prio_ptr as above.
//   LOCKED: grant only lock_id, even when lock_id is not valid (bubble; no other requester served).
//   A transfer with last=1 -> IDLE, prio_ptr <= lock_id+1 mod NUM_IN.
//   Reset -> IDLE.
//  Not defined: data_in_last ignored, no FSM, per-beat round-robin.
// TESTING
//  1 Reset: rst_n=0 with all valids high -> data_out_valid=0, data_in_ready=0, data_out_id=0. After release, first grant goes to requester 0.
//  2 NUM_IN=4, all valid, data_out_ready=1 for 8 cycles -> data_out_id sequence 0,1,2,3,0,1,2,3, one beat per cycle, each data matching its source.
//  3 Only requester 2 valid, data 0xA5A5A5A5 -> output 0xA5A5A5A5 with id=2 next cycle; then requesters 0 and 3 valid -> 3 granted before 0 (pointer at 3).
//  4 Output full, data_out_ready=0 for 5 cycles -> data_out_data/id stable, all data_in_ready=0. Ready re-raised -> no beat lost or duplicated.
//  5 Random valid/ready, 10k cycles, scoreboard per requester -> in-order, lossless, starvation bound of NUM_IN-1 grants held.
//  6 LOCK_EN: req1 sends 3-beat packet (last on 3rd), req0 valid throughout -> ids 1,1,1 then 0, with a bubble when req1 drops valid mid-packet.

Source files
------------

// File: rtl/register_slice_rr_arbiter_if.sv
// Handshake bundle between NUM_IN requesters, the shared output stage and its consumer.
// Latency: none; this file only declares wires and directions.
// Backpressure: data_out_ready from the consumer, data_in_ready (one-hot or zero) to requesters.
interface register_slice_rr_arbiter_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
  logic [NUM_IN*DATA_WIDTH-1:0] data_in_data;
  logic [NUM_IN-1:0]            data_in_valid;
  logic [NUM_IN-1:0]            data_in_last;
  logic [NUM_IN-1:0]            data_in_ready;
  logic [DATA_WIDTH-1:0]        data_out_data;
  logic [ID_WIDTH-1:0]          data_out_id;
  logic                         data_out_valid;
  logic                         data_out_ready;

  // Arbiter side: consumes requester beats, produces the registered output.
  modport slave (
    input  data_in_data, data_in_valid, data_in_last, data_out_ready,
    output data_in_ready, data_out_data, data_out_id, data_out_valid
  );

  // Environment side: requesters plus downstream consumer.
  modport master (
    output data_in_data, data_in_valid, data_in_last, data_out_ready,
    input  data_in_ready, data_out_data, data_out_id, data_out_valid
  );
endinterface

// File: rtl/register_slice_rr_arbiter.sv
// Round-robin arbiter sharing one register-slice output stage among NUM_IN valid/ready requesters.
// Latency: 1 cycle from input transfer to data_out_valid; one beat per cycle sustained.
// Backpressure: output full and data_out_ready low -> every data_in_ready low, output holds.
// Optional packet lock (whole packet from one requester) enabled by defining REGISTER_SLICE_ARB_LOCK_EN.
module register_slice_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input logic                        clk,
  input logic                        rst_n,
  register_slice_rr_arbiter_if.slave bus
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_IN - 1);

  // Successor of a requester index, wrapping after the last requester.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] g);
    return (g == LAST_ID) ? '0 : g + ID_WIDTH'(1);
  endfunction

  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] out_dat_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [ID_WIDTH-1:0]   prio_ptr_q;
  logic [ID_WIDTH-1:0]   ptr_d;

  logic                  load;
  logic                  rr_found;
  logic [ID_WIDTH-1:0]   rr_id;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic                  gnt_hit;   // granted requester is presenting a beat
  logic                  gnt_own;   // some requester owns the grant this cycle
  logic                  xfer;
  logic [DATA_WIDTH-1:0] gnt_dat;
  logic [NUM_IN-1:0]     rdy;

  // The output register can take a new beat when empty or being drained this cycle.
  assign load = bus.data_out_ready | ~out_vld_q;

  // Rotating scan starting at prio_ptr; first valid requester wins.
  always_comb begin
    int idx;
    logic [ID_WIDTH-1:0] sel;
    rr_found = 1'b0;
    rr_id    = '0;
    idx      = 0;
    sel      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(prio_ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      sel = ID_WIDTH'(idx);
      if (!rr_found && bus.data_in_valid[sel]) begin
        rr_found = 1'b1;
        rr_id    = sel;
      end
    end
  end

`ifdef REGISTER_SLICE_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;

  // Lock state register; reset always returns to per-beat arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Grant selection and lock transitions; a locked owner keeps the grant even while idle (bubble).
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    ptr_d     = prio_ptr_q;
    gnt_id    = rr_id;
    gnt_hit   = rr_found;
    gnt_own   = rr_found;
    if (state_q == LOCKED) begin
      gnt_id  = lock_id_q;
      gnt_hit = bus.data_in_valid[lock_id_q];
      gnt_own = 1'b1;
    end
    xfer = gnt_hit & load;
    if (xfer) begin
      if (state_q == IDLE) begin
        if (!bus.data_in_last[gnt_id]) begin
          state_d   = LOCKED;
          lock_id_d = gnt_id;
        end else begin
          ptr_d = wrap_inc(gnt_id);
        end
      end else if (bus.data_in_last[gnt_id]) begin
        state_d = IDLE;
        ptr_d   = wrap_inc(lock_id_q);
      end
    end
  end
`else
  // Packet boundaries are irrelevant without the lock.
  logic unused_last;
  assign unused_last = ^bus.data_in_last;

  // Per-beat grant; the pointer moves just past each winner.
  always_comb begin
    gnt_id  = rr_id;
    gnt_hit = rr_found;
    gnt_own = rr_found;
    xfer    = gnt_hit & load;
    ptr_d   = xfer ? wrap_inc(gnt_id) : prio_ptr_q;
  end
`endif

  assign gnt_dat = bus.data_in_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];

  // One-hot ready to the grant owner only while the output can load; silent during reset.
  always_comb begin
    rdy = '0;
    if (gnt_own && load && rst_n) rdy[gnt_id] = 1'b1;
  end

  // Output register and priority pointer; data/id hold when nothing new is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_id_q   <= '0;
      prio_ptr_q <= '0;
    end else begin
      if (load) begin
        out_vld_q <= xfer;
        if (xfer) begin
          out_dat_q <= gnt_dat;
          out_id_q  <= gnt_id;
        end
      end
      prio_ptr_q <= ptr_d;
    end
  end

  assign bus.data_in_ready  = rdy;
  assign bus.data_out_valid = out_vld_q;
  assign bus.data_out_data  = out_dat_q;
  assign bus.data_out_id    = out_id_q;

endmodule

// File: tb/tb_register_slice_rr_arbiter.sv
// Bench for register_slice_rr_arbiter: directed cases then a randomized run against a behavioural model.
// Latency: outputs sampled 1 time unit after each rising edge, inputs driven on falling edges.
// Backpressure: data_out_ready is randomized; requester valids stay up until accepted.
module tb_register_slice_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int RAND_CYCLES = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_slice_rr_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  register_slice_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fixed_dat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  // Drive one cycle of directed stimulus on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic dr);
    @(negedge clk);
    bus.data_in_valid  = v;
    bus.data_in_last   = l;
    bus.data_out_ready = dr;
    for (int i = 0; i < N; i++) bus.data_in_data[i*DW +: DW] = fixed_dat(i);
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input int id, input logic [DW-1:0] d);
    check({tag, "_vld"}, bus.data_out_valid, v);
    check({tag, "_id"}, bus.data_out_id, id);
    check({tag, "_dat"}, bus.data_out_data, d);
  endtask

  // Random-phase state: requester queues, scoreboard and model of the output stage.
  logic            pend [N];
  logic [DW-1:0]   pdat [N];
  int              gen  [N];
  int              got  [N];
  int              wait_cnt [N];
  logic            m_vld;
  logic [DW-1:0]   m_dat;
  int              m_id;
  int              m_ptr;
  logic            dr;
  logic            ld;
  int              g;
  int              oid;
  logic [N-1:0]    exp_rdy;

  initial begin
    rst_n              = 1'b0;
    bus.data_in_valid  = '1;
    bus.data_in_last   = '1;
    bus.data_out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.data_in_data[i*DW +: DW] = fixed_dat(i);

    // Reset with every requester asking.
    repeat (2) @(negedge clk);
    #1;
    check("rst_vld", bus.data_out_valid, 0);
    check("rst_rdy", bus.data_in_ready, 0);
    check("rst_id", bus.data_out_id, 0);
    @(negedge clk);
    bus.data_in_valid = '0;
    rst_n = 1'b1;

    // All valid, consumer always ready: strict rotation from requester 0.
    for (int k = 0; k < 8; k++) begin
      drive('1, '1, 1'b1);
      check("rot_rdy", bus.data_in_ready, 64'(1) << (k % N));
      after_edge();
      expect_out("rot", 1'b1, k % N, fixed_dat(k % N));
    end

    // Nothing valid: output empties, data/id hold.
    drive('0, '1, 1'b1);
    after_edge();
    expect_out("drain", 1'b0, 3, fixed_dat(3));

    // Single requester 2 with a distinctive beat.
    drive(4'b0100, '1, 1'b1);
    bus.data_in_data[2*DW +: DW] = 32'hA5A5_A5A5;
    check("solo_rdy", bus.data_in_ready, 4'b0100);
    after_edge();
    expect_out("solo", 1'b1, 2, 32'hA5A5_A5A5);

    // Pointer now at 3: requester 3 beats requester 0.
    drive(4'b1001, '1, 1'b1);
    check("ptr3_rdy", bus.data_in_ready, 4'b1000);
    after_edge();
    expect_out("ptr3", 1'b1, 3, fixed_dat(3));
    drive(4'b0001, '1, 1'b1);
    check("ptr0_rdy", bus.data_in_ready, 4'b0001);
    after_edge();
    expect_out("ptr0", 1'b1, 0, fixed_dat(0));

    // Stall with the output full: nothing accepted, output frozen.
    for (int k = 0; k < 5; k++) begin
      drive('1, '1, 1'b0);
      check("stall_rdy", bus.data_in_ready, 0);
      after_edge();
      expect_out("stall", 1'b1, 0, fixed_dat(0));
    end
    drive('1, '1, 1'b1);
    check("resume_rdy", bus.data_in_ready, 4'b0010);
    after_edge();
    expect_out("resume1", 1'b1, 1, fixed_dat(1));
    drive('1, '1, 1'b1);
    after_edge();
    expect_out("resume2", 1'b1, 2, fixed_dat(2));

    // Reset in the middle of traffic discards the held beat.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_out("midrst", 1'b0, 0, '0);
    check("midrst_rdy", bus.data_in_ready, 0);
    @(negedge clk);
    bus.data_in_valid = '0;
    rst_n = 1'b1;
    drive('1, '1, 1'b1);
    check("restart_rdy", bus.data_in_ready, 4'b0001);
    after_edge();
    expect_out("restart", 1'b1, 0, fixed_dat(0));

`ifdef REGISTER_SLICE_ARB_LOCK_EN
    // Pointer at 1: requester 1 sends a 3-beat packet with a gap while requester 0 keeps asking.
    drive(4'b0011, 4'b0001, 1'b1);
    check("lk1_rdy", bus.data_in_ready, 4'b0010);
    after_edge();
    expect_out("lk1", 1'b1, 1, fixed_dat(1));
    drive(4'b0011, 4'b0001, 1'b1);
    check("lk2_rdy", bus.data_in_ready, 4'b0010);
    after_edge();
    expect_out("lk2", 1'b1, 1, fixed_dat(1));
    drive(4'b0001, 4'b0001, 1'b1);
    check("lkgap_rdy", bus.data_in_ready, 4'b0010);
    after_edge();
    check("lkgap_vld", bus.data_out_valid, 0);
    drive(4'b0011, 4'b0011, 1'b1);
    check("lk3_rdy", bus.data_in_ready, 4'b0010);
    after_edge();
    expect_out("lk3", 1'b1, 1, fixed_dat(1));
    drive(4'b0001, 4'b0011, 1'b1);
    check("unlk_rdy", bus.data_in_ready, 4'b0001);
    after_edge();
    expect_out("unlk", 1'b1, 0, fixed_dat(0));
`endif

    // Randomized traffic from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    bus.data_in_valid = '0;
    bus.data_in_last  = '1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pdat[i] = '0; gen[i] = 0; got[i] = 0; wait_cnt[i] = 0;
    end
    m_vld = 1'b0; m_dat = '0; m_id = 0; m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < RAND_CYCLES + 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (c < RAND_CYCLES && !pend[i] && $urandom_range(99) < 55) begin
          pend[i] = 1'b1;
          pdat[i] = {8'(i), 24'(gen[i])};
          gen[i]++;
        end
        bus.data_in_valid[i] = pend[i];
        bus.data_in_data[i*DW +: DW] = pdat[i];
      end
      dr = (c >= RAND_CYCLES) || ($urandom_range(99) < 70);
      bus.data_out_ready = dr;
      #1;

      // Scoreboard: each requester's beats leave in generation order.
      if (bus.data_out_valid && dr) begin
        oid = int'(bus.data_out_id);
        check("sb_order", bus.data_out_data, {8'(oid), 24'(got[oid])});
        got[oid]++;
      end

      // Model: first pending requester at or after the pointer, modulo N.
      ld = dr || !m_vld;
      g  = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g] = 1'b1;
      check("rnd_rdy", bus.data_in_ready, exp_rdy);

      if (ld) begin
        if (g >= 0) begin
          for (int i = 0; i < N; i++) begin
            if (i != g && pend[i]) begin
              wait_cnt[i]++;
              check("starve", 64'(wait_cnt[i] > N - 1), 0);
            end
          end
          m_vld = 1'b1;
          m_dat = pdat[g];
          m_id  = g;
          m_ptr = (g + 1) % N;
          pend[g] = 1'b0;
          wait_cnt[g] = 0;
        end else begin
          m_vld = 1'b0;
        end
      end

      after_edge();
      expect_out("rnd", m_vld, m_id, m_dat);
    end

    for (int i = 0; i < N; i++) check("lossless", got[i], gen[i]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
